// File: rtl/alu_axi_pkg.sv
// Shared definitions for the AXI4-Lite ALU peripheral:
// register offsets, response codes, opcodes and CMP encoding.
package alu_axi_pkg;

  localparam logic [3:0] A_OFF      = 4'h0;
  localparam logic [3:0] B_OFF      = 4'h4;
  localparam logic [3:0] CTRL_OFF   = 4'h8;
  localparam logic [3:0] RESULT_OFF = 4'hC;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SHR = 3'b001;
  localparam logic [2:0] OP_POP = 3'b010;
  localparam logic [2:0] OP_CMP = 3'b011;

  localparam int CMP_LSB = 24;
  localparam int CMP_MSB = 25;

  localparam logic [1:0] CMP_EQ = 2'b00;
  localparam logic [1:0] CMP_GT = 2'b01;
  localparam logic [1:0] CMP_LT = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wst_t;
  typedef enum logic {R_IDLE, R_DATA} rst_t;

  function automatic logic [31:0] strb_merge(
    input logic [31:0] old,
    input logic [31:0] d,
    input logic [3:0]  st
  );
    logic [31:0] m;
    m = old;
    for (int i = 0; i < 4; i++)
      if (st[i]) m[8*i +: 8] = d[8*i +: 8];
    return m;
  endfunction

endpackage

// File: rtl/top_simple_cpu.sv
// Sliced ALU: N_A slices of S bits, ripple carry between slices.
// Ops: add, shift-right-1, popcount, compare.
module top_simple_cpu
  import alu_axi_pkg::*;
#(
  parameter int S   = 4,
  parameter int N_A = 2
) (
  input  logic [S*N_A-1:0] i_a,
  input  logic [S*N_A-1:0] i_b,
  input  logic [2:0]       i_op,
  output logic [S*N_A-1:0] o_result,
  output logic [1:0]       o_cmp
);

  localparam int W = S * N_A;

  logic [N_A:0] w_c;
  logic [W-1:0] w_sum;
  logic [W-1:0] w_pop;

  assign w_c[0] = 1'b0;

  for (genvar g = 0; g < N_A; g++) begin : g_slice
    assign {w_c[g+1], w_sum[g*S +: S]} =
      {1'b0, i_a[g*S +: S]} +
      {1'b0, i_b[g*S +: S]} +
      {{S{1'b0}}, w_c[g]};
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < W; i++)
      w_pop = w_pop + W'(i_a[i]);
  end

  always_comb begin
    o_result = '0;
    o_cmp    = CMP_EQ;
    case (i_op)
      OP_ADD: o_result = w_sum;
      OP_SHR: o_result = i_a >> 1;
      OP_POP: o_result = w_pop;
      OP_CMP: o_cmp = (i_a > i_b) ? CMP_GT :
                      (i_a < i_b) ? CMP_LT : CMP_EQ;
      default: ;
    endcase
  end

  // Final carry out of the top slice is intentionally dropped (add wraps).
  logic w_unused;
  assign w_unused = w_c[N_A];

endmodule

// File: rtl/axi_lite_alu_slave.sv
// AXI4-Lite register front-end for the sliced ALU.
// ALU_RESULT_REG_EN: register RESULT/CMP before the read mux.
module axi_lite_alu_slave
  import alu_axi_pkg::*;
#(
  parameter int S      = 4,
  parameter int N_A    = 2,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready
);

  localparam int W = S * N_A;

  logic       r_live;
  wst_t       r_wst, w_wst_nxt;
  rst_t       r_rst, w_rst_nxt;
  logic       w_wacc, w_racc;
  logic       w_aw_oor, w_ar_oor;
  logic [1:0] w_aw_sel, w_ar_sel;

  logic [W-1:0] r_a, r_b;
  logic [2:0]   r_op;
  logic [W-1:0] w_alu_res, w_res_rd;
  logic [1:0]   w_alu_cmp, w_cmp_rd;

  logic [31:0] w_ma, w_mb, w_mc;
  logic [31:0] w_rword, r_rdata;
  logic [1:0]  w_rresp, r_rresp;
  logic [1:0]  w_bresp, r_bresp;

  assign w_aw_oor = |(s_awaddr >> 4);
  assign w_ar_oor = |(s_araddr >> 4);
  assign w_aw_sel = s_awaddr[3:2];
  assign w_ar_sel = s_araddr[3:2];

  assign w_bresp =
    (w_aw_oor || w_aw_sel == RESULT_OFF[3:2]) ?
    RESP_SLVERR : RESP_OKAY;

  // r_live holds arready low until the first edge out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_live <= 1'b0;
      r_wst  <= W_IDLE;
      r_rst  <= R_IDLE;
    end else begin
      r_live <= 1'b1;
      r_wst  <= w_wst_nxt;
      r_rst  <= w_rst_nxt;
    end
  end

  always_comb begin
    w_wst_nxt = r_wst;
    w_wacc    = 1'b0;
    unique case (r_wst)
      W_IDLE:
        if (r_live && s_awvalid && s_wvalid) begin
          w_wacc    = 1'b1;
          w_wst_nxt = W_RESP;
        end
      W_RESP:
        if (s_bready) w_wst_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    w_rst_nxt = r_rst;
    w_racc    = 1'b0;
    unique case (r_rst)
      R_IDLE:
        if (r_live && s_arvalid) begin
          w_racc    = 1'b1;
          w_rst_nxt = R_DATA;
        end
      R_DATA:
        if (s_rready) w_rst_nxt = R_IDLE;
    endcase
  end

  assign s_awready = w_wacc;
  assign s_wready  = w_wacc;
  assign s_bvalid  = (r_wst == W_RESP);
  assign s_bresp   = r_bresp;
  assign s_arready = r_live && (r_rst == R_IDLE);
  assign s_rvalid  = (r_rst == R_DATA);
  assign s_rdata   = r_rdata;
  assign s_rresp   = r_rresp;

  assign w_ma = strb_merge(32'(r_a), s_wdata, s_wstrb);
  assign w_mb = strb_merge(32'(r_b), s_wdata, s_wstrb);
  assign w_mc = strb_merge(32'(r_op), s_wdata, s_wstrb);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_bresp <= RESP_OKAY;
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
    end else begin
      if (w_wacc) begin
        r_bresp <= w_bresp;
        if (!w_aw_oor) begin
          unique case (1'b1)
            (w_aw_sel == A_OFF[3:2]):    r_a  <= w_ma[W-1:0];
            (w_aw_sel == B_OFF[3:2]):    r_b  <= w_mb[W-1:0];
            (w_aw_sel == CTRL_OFF[3:2]): r_op <= w_mc[2:0];
            default: ;
          endcase
        end
      end
      if (w_racc) begin
        r_rdata <= w_rword;
        r_rresp <= w_rresp;
      end
    end
  end

  top_simple_cpu #(
    .S   (S),
    .N_A (N_A)
  ) u_alu (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_op     (r_op),
    .o_result (w_alu_res),
    .o_cmp    (w_alu_cmp)
  );

`ifdef ALU_RESULT_REG_EN
  logic [W-1:0] r_res;
  logic [1:0]   r_cmp;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_res <= '0;
      r_cmp <= '0;
    end else begin
      r_res <= w_alu_res;
      r_cmp <= w_alu_cmp;
    end
  end

  assign w_res_rd = r_res;
  assign w_cmp_rd = r_cmp;
`else
  assign w_res_rd = w_alu_res;
  assign w_cmp_rd = w_alu_cmp;
`endif

  always_comb begin
    w_rword = '0;
    w_rresp = RESP_OKAY;
    if (w_ar_oor) begin
      w_rresp = RESP_SLVERR;
    end else begin
      unique case (1'b1)
        (w_ar_sel == A_OFF[3:2]):    w_rword[W-1:0] = r_a;
        (w_ar_sel == B_OFF[3:2]):    w_rword[W-1:0] = r_b;
        (w_ar_sel == CTRL_OFF[3:2]): w_rword[2:0]   = r_op;
        (w_ar_sel == RESULT_OFF[3:2]): begin
          w_rword[W-1:0]           = w_res_rd;
          w_rword[CMP_MSB:CMP_LSB] = w_cmp_rd;
        end
        default: ;
      endcase
    end
  end

  // Byte-lane bits below the word select are don't-care.
  logic w_unused;
  assign w_unused = ^{s_awaddr[1:0], s_araddr[1:0]};

endmodule

// File: tb/tb_axi_lite_alu_slave.sv
// Scoreboard bench for axi_lite_alu_slave: directed bus
// transactions push expectations, a monitor checks B/R beats.
module tb_axi_lite_alu_slave;

  localparam int ADDR_W = 4;
  localparam logic [31:0] MFULL = 32'hFFFF_FFFF;
  localparam logic [31:0] MRES  = 32'hFCFF_FFFF;
  localparam logic [31:0] MCMP  = 32'h0300_0000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] s_awaddr;
  logic              s_awvalid;
  logic              s_awready;
  logic [31:0]       s_wdata;
  logic [3:0]        s_wstrb;
  logic              s_wvalid;
  logic              s_wready;
  logic [1:0]        s_bresp;
  logic              s_bvalid;
  logic              s_bready;
  logic [ADDR_W-1:0] s_araddr;
  logic              s_arvalid;
  logic              s_arready;
  logic [31:0]       s_rdata;
  logic [1:0]        s_rresp;
  logic              s_rvalid;
  logic              s_rready;

  always #5 clk = ~clk;

  axi_lite_alu_slave #(
    .S(4), .N_A(2), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid),
    .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid),
    .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid),
    .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [31:0] m;
    logic [1:0]  r;
  } rexp_t;

  rexp_t       rq[$];
  string       rn[$];
  logic [1:0]  bq[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timeout/unexpected", nm);
  endtask

  // Monitor: a beat seen here completes on the next rising edge.
  always @(negedge clk) begin
    if (s_rvalid && s_rready) begin
      if (rq.size() == 0) fail("r_unexpected");
      else begin
        rexp_t e;
        string nm;
        e  = rq.pop_front();
        nm = rn.pop_front();
        chk({nm, "_rdata"}, s_rdata & e.m, e.d & e.m);
        chk({nm, "_rresp"}, 32'(s_rresp), 32'(e.r));
      end
    end
    if (s_bvalid && s_bready) begin
      if (bq.size() == 0) fail("b_unexpected");
      else chk("bresp", 32'(s_bresp), 32'(bq.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_r(input string nm, input logic [31:0] d,
                        input logic [31:0] m, input logic [1:0] r);
    rq.push_back('{d: d, m: m, r: r});
    rn.push_back(nm);
  endtask

  task automatic wait_b(input string nm);
    int n;
    bit hs;
    n = 0;
    do begin
      @(negedge clk);
      hs = s_bvalid && s_bready;
      tick();
      n++;
    end while (!hs && n < 20);
    if (!hs) fail({nm, "_b_wait"});
  endtask

  task automatic wait_r(input string nm);
    int n;
    bit hs;
    n = 0;
    do begin
      @(negedge clk);
      hs = s_rvalid && s_rready;
      tick();
      n++;
    end while (!hs && n < 20);
    if (!hs) fail({nm, "_r_wait"});
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d,
                    input logic [3:0] st, input logic [1:0] er);
    int n;
    bit acc;
    bq.push_back(er);
    s_awaddr = a; s_wdata = d; s_wstrb = st;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      acc = s_awready && s_wready;
      tick();
      n++;
    end while (!acc && n < 20);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    if (!acc) fail("wr_accept");
    wait_b("wr");
  endtask

  task automatic rd(input string nm, input logic [3:0] a,
                    input logic [31:0] d, input logic [31:0] m,
                    input logic [1:0] er);
    int n;
    bit acc;
    push_r(nm, d, m, er);
    s_araddr = a; s_arvalid = 1'b1; s_rready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      acc = s_arready;
      tick();
      n++;
    end while (!acc && n < 20);
    s_arvalid = 1'b0;
    if (!acc) fail({nm, "_ar_accept"});
    wait_r(nm);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rq.size() != 0 || bq.size() != 0) && n < 30) begin
      tick();
      n++;
    end
    if (rq.size() != 0 || bq.size() != 0) fail("drain");
  endtask

  initial begin
    bit acc, acc2;
    int n;
    rst_n = 1'b0;
    s_awaddr = '0; s_awvalid = 1'b0;
    s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
    s_bready = 1'b0;
    s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_awready", 32'(s_awready), 0);
    chk("rst_bvalid", 32'(s_bvalid), 0);
    chk("rst_rvalid", 32'(s_rvalid), 0);
    chk("rst_rdata", s_rdata, 0);
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("post_rst_arready", 32'(s_arready), 1);
    chk("post_rst_bresp", 32'(s_bresp), 0);
    tick();

    rd("rst_a", 4'h0, 0, MFULL, 2'b00);
    rd("rst_b", 4'h4, 0, MFULL, 2'b00);
    rd("rst_ctrl", 4'h8, 0, MFULL, 2'b00);
    rd("rst_res", 4'hC, 0, MFULL, 2'b00);

    wr(4'h0, 10, 4'hF, 2'b00);
    wr(4'h4, 22, 4'hF, 2'b00);
    wr(4'h8, 0, 4'hF, 2'b00);
    rd("add_10_22", 4'hC, 32, MRES, 2'b00);
    wr(4'h0, 255, 4'hF, 2'b00);
    wr(4'h4, 1, 4'hF, 2'b00);
    rd("add_wrap", 4'hC, 0, MRES, 2'b00);

    wr(4'h8, 3, 4'hF, 2'b00);
    wr(4'h0, 200, 4'hF, 2'b00);
    wr(4'h4, 100, 4'hF, 2'b00);
    rd("cmp_gt", 4'hC, 32'h0100_0000, MCMP, 2'b00);
    wr(4'h0, 10, 4'hF, 2'b00);
    wr(4'h4, 20, 4'hF, 2'b00);
    rd("cmp_lt", 4'hC, 32'h0200_0000, MCMP, 2'b00);
    wr(4'h0, 50, 4'hF, 2'b00);
    wr(4'h4, 50, 4'hF, 2'b00);
    rd("cmp_eq", 4'hC, 32'h0000_0000, MCMP, 2'b00);

    wr(4'h8, 1, 4'hF, 2'b00);
    wr(4'h0, 32'hAD, 4'hF, 2'b00);
    rd("shr", 4'hC, 32'h56, MRES, 2'b00);
    wr(4'h8, 2, 4'hF, 2'b00);
    rd("pop", 4'hC, 5, MRES, 2'b00);
    wr(4'hC, 32'hFF, 4'hF, 2'b10);
    rd("pop_after_ro", 4'hC, 5, MRES, 2'b00);
    wr(4'h8, 4, 4'hF, 2'b00);
    rd("op4", 4'hC, 0, MFULL, 2'b00);
    wr(4'h8, 32'hFFFF_FFFF, 4'hF, 2'b00);
    rd("ctrl_7", 4'h8, 7, MFULL, 2'b00);
    rd("op7", 4'hC, 0, MFULL, 2'b00);

    wr(4'h0, 32'h1234_5678, 4'hF, 2'b00);
    rd("a_trunc", 4'h0, 32'h78, MFULL, 2'b00);
    wr(4'h0, 32'hFFFF_FF99, 4'hE, 2'b00);
    rd("a_strb_hi", 4'h0, 32'h78, MFULL, 2'b00);
    wr(4'h0, 32'h0000_00AB, 4'h1, 2'b00);
    rd("a_strb_lo", 4'h0, 32'hAB, MFULL, 2'b00);
    wr(4'h5, 32'h33, 4'hF, 2'b00);
    rd("b_lowbits", 4'h6, 32'h33, MFULL, 2'b00);

    // Read stall: rvalid/rdata held, further AR refused.
    push_r("rstall", 32'hAB, MFULL, 2'b00);
    s_araddr = 4'h0; s_arvalid = 1'b1; s_rready = 1'b0;
    n = 0;
    do begin
      @(negedge clk); acc = s_arready; tick(); n++;
    end while (!acc && n < 20);
    if (!acc) fail("rstall_accept");
    s_araddr = 4'h4;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rstall_rvalid", 32'(s_rvalid), 1);
      chk("rstall_rdata", s_rdata, 32'hAB);
      chk("rstall_arready", 32'(s_arready), 0);
      tick();
    end
    s_arvalid = 1'b0; s_rready = 1'b1;
    wait_r("rstall");

    // Write stall: bvalid held, further AW/W refused.
    bq.push_back(2'b00);
    s_awaddr = 4'h4; s_wdata = 32'h44; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b0;
    n = 0;
    do begin
      @(negedge clk); acc = s_awready; tick(); n++;
    end while (!acc && n < 20);
    if (!acc) fail("wstall_accept");
    s_wdata = 32'h55;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("wstall_bvalid", 32'(s_bvalid), 1);
      chk("wstall_bresp", 32'(s_bresp), 0);
      chk("wstall_awready", 32'(s_awready), 0);
      tick();
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b1;
    wait_b("wstall");
    rd("b_after_stall", 4'h4, 32'h44, MFULL, 2'b00);

    // AW three cycles ahead of W.
    bq.push_back(2'b00);
    s_awaddr = 4'h4; s_wdata = 32'h66; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b0; s_bready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("aw_only_ready", 32'(s_awready), 0);
      tick();
    end
    s_wvalid = 1'b1;
    n = 0;
    do begin
      @(negedge clk); acc = s_awready; tick(); n++;
    end while (!acc && n < 20);
    if (!acc) fail("aw_w_accept");
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    wait_b("aw_first");
    rd("b_aw_first", 4'h4, 32'h66, MFULL, 2'b00);

    // Reset while rvalid is high: response dropped.
    s_araddr = 4'h0; s_arvalid = 1'b1; s_rready = 1'b0;
    n = 0;
    do begin
      @(negedge clk); acc = s_arready; tick(); n++;
    end while (!acc && n < 20);
    if (!acc) fail("rrst_accept");
    s_arvalid = 1'b0;
    @(negedge clk);
    chk("rrst_rvalid_pre", 32'(s_rvalid), 1);
    tick();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    chk("rrst_rvalid_post", 32'(s_rvalid), 0);
    rst_n = 1'b1;
    s_rready = 1'b1;
    tick();
    @(negedge clk);
    chk("rrst_arready", 32'(s_arready), 1);
    tick();
    rd("a_after_rst", 4'h0, 0, MFULL, 2'b00);

    // RESULT read accepted one edge after an operand write.
    wr(4'h0, 1, 4'hF, 2'b00);
    wr(4'h4, 2, 4'hF, 2'b00);
    bq.push_back(2'b00);
`ifdef ALU_RESULT_REG_EN
    push_r("res_k1", 3, MRES, 2'b00);
`else
    push_r("res_k1", 7, MRES, 2'b00);
`endif
    s_awaddr = 4'h0; s_wdata = 5; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    s_bready = 1'b1; s_rready = 1'b1;
    n = 0;
    do begin
      @(negedge clk); acc = s_awready; tick(); n++;
    end while (!acc && n < 20);
    if (!acc) fail("k1_w_accept");
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    s_araddr = 4'hC; s_arvalid = 1'b1;
    @(negedge clk);
    chk("k1_arready", 32'(s_arready), 1);
    tick();
    s_arvalid = 1'b0;
    drain();
    rd("res_late", 4'hC, 7, MRES, 2'b00);

    // AR and write to A accepted on the same edge.
    bq.push_back(2'b00);
    push_r("same_edge", 5, MFULL, 2'b00);
    s_awaddr = 4'h0; s_wdata = 9; s_wstrb = 4'hF;
    s_araddr = 4'h0;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
    @(negedge clk);
    acc  = s_awready;
    acc2 = s_arready;
    chk("same_edge_awready", 32'(acc), 1);
    chk("same_edge_arready", 32'(acc2), 1);
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    drain();
    rd("a_after_same", 4'h0, 9, MFULL, 2'b00);

    drain();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
